// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Receives a serial program image one byte at a time and writes it into the
// instruction memory as 32-bit little-endian words, holding the core in reset
// until a complete frame with a good checksum has been stored.
//
// Frame: LEN_LO, LEN_HI (16-bit word count N), 4*N payload bytes, checksum.
// The checksum is the XOR of every byte that precedes it.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst_n       synchronous active-low reset
//   start       single-cycle pulse that opens a load session
//   byte_in     serial program byte
//   byte_valid  byte_in holds a valid byte
//   byte_ready  loader consumes byte_in this cycle (when byte_valid is high)
//   imem_we     one-cycle write strobe per assembled word
//   imem_addr   byte address of the word being written
//   imem_wdata  assembled instruction word
//   core_hold   keeps the core in reset; low only after a good load
//   done        load finished with a good checksum (level)
//   error       load aborted (oversize count or bad checksum, level)
// -----------------------------------------------------------------------------
module imem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        core_hold,
   output logic        done,
   output logic        error
);

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      CHECK,
      DONE,
      ERROR
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [15:0] len;
   logic [15:0] word_idx;
   logic [1:0]  byte_idx;
   logic [23:0] word_buf;
   logic [7:0]  checksum;

   logic        accept;
   logic [15:0] len_word;
   logic        last_word;

   // Word count as it will look once LEN_HI is taken, so the oversize and
   // zero-length decisions can be made in the same cycle the byte arrives.
   assign len_word  = {byte_in, len[7:0]};
   assign last_word = (word_idx == (len - 16'd1));

   // State register; reset wins over everything else in the cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and status decode. Status outputs are pure functions of the
   // state, so they change exactly one cycle after the deciding byte.
   always_comb begin
      state_next = state;
      byte_ready = 1'b0;
      core_hold  = 1'b1;
      done       = 1'b0;
      error      = 1'b0;

      case (state)
         LEN_LO, LEN_HI, DATA, CHECK: byte_ready = 1'b1;
         default:                     byte_ready = 1'b0;
      endcase

      accept = byte_valid && byte_ready;

      case (state)
         IDLE: begin
            if (start) state_next = LEN_LO;
         end
         LEN_LO: begin
            if (accept) state_next = LEN_HI;
         end
         LEN_HI: begin
            if (accept) begin
               if (32'(len_word) > MAX_WORDS) state_next = ERROR;
               else if (len_word == 16'd0)    state_next = CHECK;
               else                           state_next = DATA;
            end
         end
         DATA: begin
            if (accept && (byte_idx == 2'd3) && last_word) state_next = CHECK;
         end
         CHECK: begin
            if (accept) state_next = (byte_in == checksum) ? DONE : ERROR;
         end
         DONE: begin
            core_hold = 1'b0;
            done      = 1'b1;
            if (start) state_next = LEN_LO;
         end
         ERROR: begin
            error = 1'b1;
            if (start) state_next = LEN_LO;
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath: length capture, running checksum, word assembly and the
   // memory write port. A session start clears the per-frame counters;
   // the write strobe is only ever high for the cycle after a 4th byte.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         len        <= 16'd0;
         word_idx   <= 16'd0;
         byte_idx   <= 2'd0;
         word_buf   <= 24'd0;
         checksum   <= 8'd0;
         imem_we    <= 1'b0;
         imem_addr  <= BASE_ADDR;
         imem_wdata <= 32'd0;
      end else begin
         imem_we <= 1'b0;

         if (((state == IDLE) || (state == DONE) || (state == ERROR)) && start) begin
            word_idx <= 16'd0;
            byte_idx <= 2'd0;
            checksum <= 8'd0;
         end

         if (accept) begin
            checksum <= checksum ^ byte_in;
            case (state)
               LEN_LO: len[7:0]  <= byte_in;
               LEN_HI: len[15:8] <= byte_in;
               DATA: begin
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0: word_buf[7:0]   <= byte_in;
                     2'd1: word_buf[15:8]  <= byte_in;
                     2'd2: word_buf[23:16] <= byte_in;
                     default: begin
                        imem_we    <= 1'b1;
                        imem_addr  <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                        imem_wdata <= {byte_in, word_buf};
                        word_idx   <= word_idx + 16'd1;
                     end
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001: Parameter BASE_ADDR, 32'h0000_0000, byte address of the first instruction word written.
REQ-002: Parameter MAX_WORDS, 256, largest accepted word count; any larger count is an error.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: rst_n  input  1  reset, synchronous and active-low.
REQ-005: start  input  1  single-cycle pulse that begins a load session.
REQ-006: byte_in  input  8  serial program byte.
REQ-007: byte_valid  input  1  byte_in holds a valid byte.
REQ-008: byte_ready  output  1  loader accepts byte_in this cycle.
REQ-009: imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010: imem_addr  output  32  instruction-memory byte address for the write.
REQ-011: imem_wdata  output  32  instruction word to write.
REQ-012: core_hold  output  1  holds the core in reset; low only after a successful load.
REQ-013: done  output  1  load completed with a good checksum; level signal.
REQ-014: error  output  1  load aborted; level signal.

Function
REQ-015: Frame format: LEN_LO, LEN_HI (16-bit word count N), then 4*N payload bytes, then 1 checksum byte. Each word is little-endian: byte 0 goes to imem_wdata[7:0].
REQ-016: Checksum: XOR of every byte before the checksum byte, including LEN_LO and LEN_HI. A frame is good when the received checksum byte equals this XOR.
REQ-017: A byte is accepted only in a cycle where byte_valid and byte_ready are both 1. The source holds byte_in stable while byte_valid=1 and byte_ready=0.
REQ-018: FSM states: IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR.
REQ-019: IDLE, DONE and ERROR each go to LEN_LO on start=1. Entering LEN_LO clears the checksum, the word index, the byte index, done and error.
REQ-020: LEN_LO goes to LEN_HI on acceptance.
REQ-021: LEN_HI transitions on acceptance:
- N > MAX_WORDS: go to ERROR.
- N = 0: go to CHECK.
- otherwise: go to DATA.
REQ-022: DATA accumulates 4 bytes per word. When the 4th byte is accepted:
- the next cycle has imem_we=1 for exactly one cycle;
- imem_addr = BASE_ADDR + 4*word_index, and imem_wdata holds the assembled word;
- word_index increments;
- after word N-1, the FSM goes to CHECK.
REQ-023: CHECK transitions on acceptance: go to DONE if the checksum matches, otherwise go to ERROR.
REQ-024: byte_ready is 1 exactly in LEN_LO, LEN_HI, DATA and CHECK, and 0 in IDLE, DONE and ERROR.
REQ-025: start asserted in LEN_LO, LEN_HI, DATA or CHECK is ignored; the session continues.
REQ-026: core_hold is 1 in every state except DONE. It goes low the cycle after DONE is entered.
REQ-027: done is 1 only in DONE; error is 1 only in ERROR.
REQ-028: imem_addr and imem_wdata are held at their last values when imem_we=0.
REQ-029: Word addresses are computed modulo 2^32; wrap-around is not flagged.
REQ-030: Bytes presented in IDLE, DONE or ERROR are not consumed and do not affect state.

Reset
REQ-031: rst_n=0 sampled at a clock edge sets:
- state to IDLE;
- core_hold=1;
- byte_ready, imem_we, done and error to 0;
- imem_addr=BASE_ADDR and imem_wdata=0;
- the checksum and all counters to 0.
REQ-032: rst_n=0 in the middle of a session aborts it with no further imem_we. Words already written are left as they are.
REQ-033: Reset takes priority over start and byte acceptance in the same cycle.

Verification
REQ-034: One-word load.
- Stimulus: start, then bytes 01 00 93 00 50 00 C2, each with byte_valid=1.
- Response: one imem_we pulse with imem_addr=0 and imem_wdata=32'h0050_0093; done=1; core_hold=0; error=0.
REQ-035: Bad checksum.
- Stimulus: the same frame with the final byte 00.
- Response: one imem_we pulse; then error=1, done=0, core_hold=1.
REQ-036: Zero-length load.
- Stimulus: start, then bytes 00 00 00.
- Response: no imem_we; done=1; core_hold=0.
REQ-037: Oversize count with MAX_WORDS=256.
- Stimulus: start, then bytes 01 01 (N=257).
- Response: error=1 immediately after the 2nd byte; byte_ready=0; no imem_we.
REQ-038: Backpressure.
- Stimulus: a two-word frame with byte_valid toggled randomly.
- Response: imem_we pulses at addresses 0 then 4 with the correct data. start pulsed mid-frame is ignored.
REQ-039: Mid-frame reset.
- Stimulus: rst_n=0 after 3 payload bytes.
- Response: the next cycle shows state IDLE, core_hold=1, imem_we=0. A following full frame loads correctly.
